muldiv_ctrl: RTL and testbench

Sequencing controller for the RV32M execute path. It accepts one M-extension operation at a time from the EX stage over a valid/ready handshake. Multiply selects go to the team's combinational `mul` unit, with the result registered. Divide and remainder selects run an internal 32-iteration restoring divider. The result is held until the consumer accepts it, and BUSY drives the pipeline stall logic.

---
 rtl/muldiv_pkg.sv | 47 ++++
 rtl/mul.sv | 35 +++
 rtl/muldiv_div_iter.sv | 68 ++++++
 rtl/muldiv_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the RV32M multiply/divide
//               sequencing controller (width, funct3 encodings, FSM states,
//               divider iteration count, special-case result helper).
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    // funct3 encodings of the M extension
    localparam logic [2:0] SEL_MUL    = 3'b000;
    localparam logic [2:0] SEL_MULH   = 3'b001;
    localparam logic [2:0] SEL_MULHSU = 3'b010;
    localparam logic [2:0] SEL_MULHU  = 3'b011;
    localparam logic [2:0] SEL_DIV    = 3'b100;
    localparam logic [2:0] SEL_DIVU   = 3'b101;
    localparam logic [2:0] SEL_REM    = 3'b110;
    localparam logic [2:0] SEL_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // RISC-V architected results for divide-by-zero and signed overflow.
    // is_rem selects the remainder flavour (funct3 bit 1).
    function automatic logic [XLEN-1:0] special_result(
        input logic            is_rem,
        input logic [XLEN-1:0] dividend,
        input logic            div_zero
    );
        if (div_zero)
            return is_rem ? dividend : {XLEN{1'b1}};
        else
            return is_rem ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul.sv
`default_nettype none
// ============================================================================
// Module      : mul
// Description : Combinational 32x32 multiplier for MUL/MULH/MULHSU/MULHU.
//               sel_i is funct3[1:0]; 00 returns the low word, the others
//               return the high word with the appropriate operand signedness.
// Revision    : 1.0 - initial release
// ============================================================================
module mul
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [1:0]      sel_i,
    output logic [XLEN-1:0] result_o
);

    logic                   a_sgn;
    logic                   b_sgn;
    logic signed [XLEN:0]   a_ext;
    logic signed [XLEN:0]   b_ext;
    logic signed [2*XLEN-1:0] prod;

    // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MUL/MULH
    assign a_sgn = (sel_i != 2'b11);
    assign b_sgn = (sel_i == 2'b00) || (sel_i == 2'b01);
    assign a_ext = $signed({a_sgn & a_i[XLEN-1], a_i});
    assign b_ext = $signed({b_sgn & b_i[XLEN-1], b_i});

    // Low 2*XLEN bits of the extended product are exact modulo 2^64
    assign prod     = (2*XLEN)'(a_ext) * (2*XLEN)'(b_ext);
    assign result_o = (sel_i == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

endmodule
`default_nettype wire

// File: rtl/muldiv_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Unsigned restoring divider datapath. load_i captures the
//               dividend/divisor; each en_i cycle performs one shift/subtract
//               step. After DIV_ITERS steps quotient_o/remainder_o are final.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            en_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // One restoring step: shift next dividend bit into the partial remainder,
    // keep the subtraction only when it does not go negative.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (en_i) begin
            if (!diff[XLEN]) begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : RV32M sequencing controller. Accepts one operation at a time,
//               routes multiplies to the combinational mul unit and runs
//               divides/remainders on a 32-step restoring divider, then holds
//               the registered result until the consumer takes it.
//               Optional: define MULDIV_EARLY_OUT_EN to finish divide-by-zero
//               and signed overflow at the accept edge.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            VALID_IN,
    output logic            READY_OUT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic [2:0]      SELECT,
    input  logic            FLUSH,
    output logic [XLEN-1:0] RESULT,
    output logic            RESULT_VALID,
    input  logic            RESULT_READY,
    output logic            BUSY
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [XLEN-1:0]   op1_q, op1_d;
    logic [XLEN-1:0]   op2_q, op2_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dbz_q, dbz_d;
    logic              spec_q, spec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              in_signed;
    logic              in_dbz;
    logic              in_ovf;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   quo_raw;
    logic [XLEN-1:0]   rem_raw;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic              div_load;
    logic              div_en;

    // Request qualification and operand preprocessing for signed divides
    assign READY_OUT = (state_q == ST_IDLE) && !RESET;
    assign accept    = VALID_IN && READY_OUT && !FLUSH;
    assign in_signed = SELECT[2] && !SELECT[0];
    assign in_dbz    = (DATA2 == '0);
    assign in_ovf    = in_signed && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
    assign abs1      = (in_signed && DATA1[XLEN-1]) ? -DATA1 : DATA1;
    assign abs2      = (in_signed && DATA2[XLEN-1]) ? -DATA2 : DATA2;

    mul u_mul (
        .a_i      (op1_q),
        .b_i      (op2_q),
        .sel_i    (sel_q),
        .result_o (mul_res)
    );

    div_iter u_div_iter (
        .clk         (CLK),
        .rst         (RESET),
        .load_i      (div_load),
        .en_i        (div_en),
        .dividend_i  (abs1),
        .divisor_i   (abs2),
        .quotient_o  (quo_raw),
        .remainder_o (rem_raw)
    );

    assign quo_fix = neg_quo_q ? -quo_raw : quo_raw;
    assign rem_fix = neg_rem_q ? -rem_raw : rem_raw;

    // FSM next state, operand latching, counter and result update
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        spec_d    = spec_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        div_load  = 1'b0;
        div_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sel_d     = SELECT[1:0];
                    op1_d     = DATA1;
                    op2_d     = DATA2;
                    neg_quo_d = in_signed && (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
                    neg_rem_d = in_signed && DATA1[XLEN-1];
                    dbz_d     = in_dbz;
                    spec_d    = in_dbz || in_ovf;
                    cnt_d     = '0;
                    if (!SELECT[2]) begin
                        state_d = ST_MUL;
                    end else begin
                        div_load = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                        if (in_dbz || in_ovf) begin
                            state_d  = ST_DONE;
                            result_d = special_result(SELECT[1], DATA1, in_dbz);
                        end else begin
                            state_d  = ST_DIV;
                        end
`else
                        state_d  = ST_DIV;
`endif
                    end
                end
            end
            ST_MUL: begin
                result_d = mul_res;
                state_d  = ST_DONE;
            end
            ST_DIV: begin
                div_en = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST)
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                if (spec_q)
                    result_d = special_result(sel_q[1], op1_q, dbz_q);
                else
                    result_d = sel_q[1] ? rem_fix : quo_fix;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (RESULT_READY)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over any in-flight progress; the pending result is dropped
        if (FLUSH && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            cnt_d    = '0;
            div_en   = 1'b0;
        end
    end

    // Control and result registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            spec_q    <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            spec_q    <= spec_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign RESULT       = result_q;
    assign RESULT_VALID = (state_q == ST_DONE);
    assign BUSY         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Directed self-checking bench for muldiv_ctrl: reset values,
//               multiply/divide results and latency, special cases, result
//               hold, flush/reset abort and back-to-back acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 0;
`else
    localparam int SPECIAL_LAT = 33;
`endif
    localparam int MUL_LAT = 1;
    localparam int DIV_LAT = 33;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        VALID_IN = 1'b0;
    logic        READY_OUT;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic [2:0]  SELECT = '0;
    logic        FLUSH = 1'b0;
    logic [31:0] RESULT;
    logic        RESULT_VALID;
    logic        RESULT_READY = 1'b0;
    logic        BUSY;

    int checks   = 0;
    int failures = 0;

    muldiv_ctrl u_dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .VALID_IN     (VALID_IN),
        .READY_OUT    (READY_OUT),
        .DATA1        (DATA1),
        .DATA2        (DATA2),
        .SELECT       (SELECT),
        .FLUSH        (FLUSH),
        .RESULT       (RESULT),
        .RESULT_VALID (RESULT_VALID),
        .RESULT_READY (RESULT_READY),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    // Issue one request from an idle cycle (#1 after an edge); returns the
    // number of edges after the accept edge until RESULT_VALID (-1 on timeout)
    task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input bit consume, output int lat, output logic [31:0] res);
        SELECT   = sel;
        DATA1    = a;
        DATA2    = b;
        VALID_IN = 1'b1;
        @(posedge CLK); #1;
        VALID_IN = 1'b0;
        lat = 0;
        while (!RESULT_VALID && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        if (!RESULT_VALID) lat = -1;
        res = RESULT;
        if (consume) begin
            RESULT_READY = 1'b1;
            @(posedge CLK); #1;
            RESULT_READY = 1'b0;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({READY_OUT, RESULT_VALID, BUSY} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got ready/valid/busy=%b required 000", {READY_OUT, RESULT_VALID, BUSY});
        end
        checks++;
        if (RESULT !== 32'h0) begin
            failures++;
            $display("FAIL reset_result: got %h required 00000000", RESULT);
        end
        RESET = 1'b0;
        #1;
        checks++;
        if (READY_OUT !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b required 1", READY_OUT);
        end
    endtask

    task automatic test_mul();
        int          lat;
        logic [31:0] res;
        logic [2:0]  sels [3] = '{SEL_MULH, SEL_MULHU, SEL_MUL};
        logic [31:0] a    [3] = '{32'h00000003, 32'h00000003, 32'hFFFFFFF9};
        logic [31:0] b    [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000006};
        logic [31:0] exp  [3] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFD6};
        for (int i = 0; i < 3; i++) begin
            run_op(sels[i], a[i], b[i], 1'b1, lat, res);
            checks++;
            if (res !== exp[i]) begin
                failures++;
                $display("FAIL mul_result[%0d]: got %h required %h", i, res, exp[i]);
            end
            checks++;
            if (lat !== MUL_LAT) begin
                failures++;
                $display("FAIL mul_latency[%0d]: got %0d required %0d", i, lat, MUL_LAT);
            end
        end
    endtask

    task automatic test_div();
        int          lat;
        logic [31:0] res;
        logic [2:0]  sels [5] = '{SEL_DIV, SEL_REM, SEL_DIV, SEL_REM, SEL_DIVU};
        logic [31:0] a    [5] = '{32'h00000007, 32'h00000007, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF};
        logic [31:0] b    [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000002, 32'h00000002, 32'h00000010};
        logic [31:0] exp  [5] = '{32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0FFFFFFF};
        for (int i = 0; i < 5; i++) begin
            run_op(sels[i], a[i], b[i], 1'b1, lat, res);
            checks++;
            if (res !== exp[i]) begin
                failures++;
                $display("FAIL div_result[%0d]: got %h required %h", i, res, exp[i]);
            end
            checks++;
            if (lat !== DIV_LAT) begin
                failures++;
                $display("FAIL div_latency[%0d]: got %0d required %0d", i, lat, DIV_LAT);
            end
        end
    endtask

    task automatic test_special();
        int          lat;
        logic [31:0] res;
        logic [2:0]  sels [6] = '{SEL_DIVU, SEL_REMU, SEL_DIV, SEL_REM, SEL_DIV, SEL_REM};
        logic [31:0] a    [6] = '{32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] b    [6] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        logic [31:0] exp  [6] = '{32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9};
        for (int i = 0; i < 6; i++) begin
            run_op(sels[i], a[i], b[i], 1'b1, lat, res);
            checks++;
            if (res !== exp[i]) begin
                failures++;
                $display("FAIL special_result[%0d]: got %h required %h", i, res, exp[i]);
            end
            checks++;
            if (lat !== SPECIAL_LAT) begin
                failures++;
                $display("FAIL special_latency[%0d]: got %0d required %0d", i, lat, SPECIAL_LAT);
            end
        end
    endtask

    task automatic test_hold();
        int          lat;
        logic [31:0] res;
        run_op(SEL_MUL, 32'd5, 32'd6, 1'b0, lat, res);
        checks++;
        if (res !== 32'd30 || lat !== MUL_LAT) begin
            failures++;
            $display("FAIL hold_first: got %h lat %0d required 0000001e lat %0d", res, lat, MUL_LAT);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            checks++;
            if ({RESULT_VALID, READY_OUT, BUSY, RESULT} !== {3'b101, 32'd30}) begin
                failures++;
                $display("FAIL hold_cycle[%0d]: got valid/ready/busy=%b result %h required 101 0000001e",
                         i, {RESULT_VALID, READY_OUT, BUSY}, RESULT);
            end
        end
        // Consume with a new request already pending: it must not be taken
        // on the same edge the result is consumed.
        SELECT       = SEL_MUL;
        DATA1        = 32'd2;
        DATA2        = 32'd2;
        VALID_IN     = 1'b1;
        RESULT_READY = 1'b1;
        @(posedge CLK); #1;
        RESULT_READY = 1'b0;
        checks++;
        if ({RESULT_VALID, READY_OUT, BUSY} !== 3'b010) begin
            failures++;
            $display("FAIL hold_release: got valid/ready/busy=%b required 010", {RESULT_VALID, READY_OUT, BUSY});
        end
        VALID_IN = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] res;
        run_op(SEL_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, res);
        checks++;
        if (res !== 32'hFFFFFFFF || lat !== MUL_LAT) begin
            failures++;
            $display("FAIL b2b_mulhsu: got %h lat %0d required ffffffff lat %0d", res, lat, MUL_LAT);
        end
        run_op(SEL_REMU, 32'd100, 32'd7, 1'b1, lat, res);
        checks++;
        if (res !== 32'd2 || lat !== DIV_LAT) begin
            failures++;
            $display("FAIL b2b_remu: got %h lat %0d required 00000002 lat %0d", res, lat, DIV_LAT);
        end
    endtask

    // Start a signed divide and let it run 10 iterations; reports whether
    // RESULT_VALID ever rose in that window.
    task automatic start_div_10(output bit saw_valid);
        saw_valid = 1'b0;
        SELECT    = SEL_DIV;
        DATA1     = 32'd1000;
        DATA2     = 32'd7;
        VALID_IN  = 1'b1;
        @(posedge CLK); #1;
        VALID_IN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (RESULT_VALID) saw_valid = 1'b1;
        end
    endtask

    task automatic test_flush();
        int          lat;
        logic [31:0] res;
        bit          saw;
        start_div_10(saw);
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        checks++;
        if ({saw, RESULT_VALID, BUSY, READY_OUT} !== 4'b0001) begin
            failures++;
            $display("FAIL flush_abort: got saw/valid/busy/ready=%b required 0001", {saw, RESULT_VALID, BUSY, READY_OUT});
        end
        // FLUSH in IDLE blocks a simultaneous request
        SELECT   = SEL_MUL;
        DATA1    = 32'd9;
        DATA2    = 32'd9;
        VALID_IN = 1'b1;
        FLUSH    = 1'b1;
        @(posedge CLK); #1;
        VALID_IN = 1'b0;
        FLUSH    = 1'b0;
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_block: got busy %b required 0", BUSY);
        end
        run_op(SEL_MUL, 32'd3, 32'd1, 1'b1, lat, res);
        checks++;
        if (res !== 32'd3 || lat !== MUL_LAT) begin
            failures++;
            $display("FAIL flush_then_mul: got %h lat %0d required 00000003 lat %0d", res, lat, MUL_LAT);
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [31:0] res;
        bit          saw;
        start_div_10(saw);
        RESET = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if ({saw, RESULT_VALID, BUSY, READY_OUT} !== 4'b0000 || RESULT !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: got saw/valid/busy/ready=%b result %h required 0000 00000000",
                     {saw, RESULT_VALID, BUSY, READY_OUT}, RESULT);
        end
        RESET = 1'b0;
        #1;
        checks++;
        if (READY_OUT !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_ready: got %b required 1", READY_OUT);
        end
        run_op(SEL_MUL, 32'd3, 32'd1, 1'b1, lat, res);
        checks++;
        if (res !== 32'd3 || lat !== MUL_LAT) begin
            failures++;
            $display("FAIL reset_then_mul: got %h lat %0d required 00000003 lat %0d", res, lat, MUL_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
